// File: rtl/alu_32.sv
// Multi-cycle 32-bit MIPS ALU: IDLE -> EXEC -> DONE with start/finish handshake.
// Optional signed-overflow detection is compiled in with `define ALU_32_OVERFLOW_EN.
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             err_illegal_alu_control,
    output logic             busy,
    output logic             finish
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    logic [1:0]       state;
    req_t             req;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res_nxt;
    logic             ill_nxt;

    assign sum  = req.a + req.b;
    assign diff = req.a - req.b;
    assign busy = (state == S_EXEC);

    always_comb begin
        res_nxt = '0;
        ill_nxt = 1'b0;
        case (req.op)
            OP_AND:  res_nxt = req.a & req.b;
            OP_OR:   res_nxt = req.a | req.b;
            OP_ADD:  res_nxt = sum;
            OP_SUB:  res_nxt = diff;
            OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, $signed(req.a) < $signed(req.b)};
            OP_NOR:  res_nxt = ~(req.a | req.b);
            default: ill_nxt = 1'b1;
        endcase
    end

`ifdef ALU_32_OVERFLOW_EN
    logic ovf_nxt;

    always_comb begin
        ovf_nxt = 1'b0;
        case (req.op)
            OP_ADD:  ovf_nxt = (req.a[WIDTH-1] == req.b[WIDTH-1]) && (sum[WIDTH-1] != req.a[WIDTH-1]);
            OP_SUB:  ovf_nxt = (req.a[WIDTH-1] != req.b[WIDTH-1]) && (diff[WIDTH-1] != req.a[WIDTH-1]);
            default: ovf_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (state == S_EXEC)
            overflow <= ovf_nxt;
    end
`else
    assign overflow = 1'b0;
`endif

    // Start is only honoured in IDLE/DONE, so a pulse during EXEC is simply lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                   <= S_IDLE;
            req                     <= '0;
            result                  <= '0;
            zero                    <= 1'b1;
            err_illegal_alu_control <= 1'b0;
            finish                  <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                S_EXEC: begin
                    result                  <= res_nxt;
                    zero                    <= (res_nxt == '0);
                    err_illegal_alu_control <= ill_nxt;
                    finish                  <= 1'b1;
                    state                   <= S_DONE;
                end
                default: begin
                    if (start) begin
                        req   <= '{op: alu_control, a: a, b: b};
                        state <= S_EXEC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32; overflow expectations follow ALU_32_OVERFLOW_EN.
module tb_alu_32;

`ifdef ALU_32_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        err_illegal_alu_control;
    logic        busy;
    logic        finish;

    int n_chk = 0;
    int n_err = 0;

    alu_32 #(.WIDTH(32)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .alu_control             (alu_control),
        .a                       (a),
        .b                       (b),
        .result                  (result),
        .zero                    (zero),
        .overflow                (overflow),
        .err_illegal_alu_control (err_illegal_alu_control),
        .busy                    (busy),
        .finish                  (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs during EXEC, check at k+1 and hold at k+2.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] er, input logic eo,
                          input logic ee);
        start = 1'b1; alu_control = op; a = va; b = vb;
        step();
        chk({tag, ".busy_k"}, {31'b0, busy}, 32'd1);
        chk({tag, ".fin_k"}, {31'b0, finish}, 32'd0);
        start = 1'b0; a = ~va; b = vb ^ 32'h5A5A_A5A5; alu_control = 4'b0010;
        step();
        chk({tag, ".fin"}, {31'b0, finish}, 32'd1);
        chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
        chk({tag, ".res"}, result, er);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, er == 32'd0});
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, eo});
        chk({tag, ".err"}, {31'b0, err_illegal_alu_control}, {31'b0, ee});
        step();
        chk({tag, ".fin_off"}, {31'b0, finish}, 32'd0);
        chk({tag, ".hold"}, result, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin_cnt;
        int busy_cnt;
        rst_n = 1'b0; start = 1'b1; alu_control = 4'b0010; a = 32'd9; b = 32'd9;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst.res", result, 32'd0);
            chk("rst.zero", {31'b0, zero}, 32'd1);
            chk("rst.fin", {31'b0, finish}, 32'd0);
            chk("rst.busy", {31'b0, busy}, 32'd0);
            chk("rst.ovf", {31'b0, overflow}, 32'd0);
            chk("rst.err", {31'b0, err_illegal_alu_control}, 32'd0);
        end
        rst_n = 1'b1; start = 1'b0;
        step();

        run_op("add",     4'b0010, 32'd5,         32'd7,         32'd12,        1'b0,   1'b0);
        run_op("sub0",    4'b0110, 32'd7,         32'd7,         32'd0,         1'b0,   1'b0);
        run_op("and",     4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0,   1'b0);
        run_op("or",      4'b0001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0,   1'b0);
        run_op("nor",     4'b1100, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0,   1'b0);
        run_op("slt_m1",  4'b0111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0,   1'b0);
        run_op("slt_p1",  4'b0111, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0,   1'b0);
        run_op("slt_min", 4'b0111, 32'h8000_0000, 32'd1,         32'd1,         1'b0,   1'b0);
        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, OVF_EN, 1'b0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, OVF_EN, 1'b0);
        run_op("add_neg", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0,   1'b0);
        run_op("illegal", 4'b1111, 32'd3,         32'd4,         32'd0,         1'b0,   1'b1);
        run_op("legal",   4'b0010, 32'd1,         32'd2,         32'd3,         1'b0,   1'b0);

        // Start during EXEC is dropped
        start = 1'b1; alu_control = 4'b0010; a = 32'd10; b = 32'd20;
        step();
        chk("drop.busy", {31'b0, busy}, 32'd1);
        start = 1'b1; a = 32'd100; b = 32'd200;
        step();
        chk("drop.fin", {31'b0, finish}, 32'd1);
        chk("drop.res", result, 32'd30);
        start = 1'b0;
        step();
        chk("drop.fin2", {31'b0, finish}, 32'd0);
        chk("drop.busy2", {31'b0, busy}, 32'd0);
        step();
        chk("drop.fin3", {31'b0, finish}, 32'd0);
        chk("drop.res2", result, 32'd30);

        // Back-to-back: start held for 6 edges
        fin_cnt = 0; busy_cnt = 0;
        start = 1'b1; alu_control = 4'b0010; a = 32'd5; b = 32'd7;
        for (int i = 0; i < 6; i++) begin
            step();
            if (finish) fin_cnt++;
            if (busy) busy_cnt++;
            chk("b2b.alt", {31'b0, finish}, {31'b0, i[0]});
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (finish) fin_cnt++;
            if (busy) busy_cnt++;
        end
        chk("b2b.fin_cnt", fin_cnt, 32'd3);
        chk("b2b.busy_cnt", busy_cnt, 32'd3);
        chk("b2b.res", result, 32'd12);

        // Abort during EXEC
        start = 1'b1; alu_control = 4'b0001; a = 32'hAAAA_0000; b = 32'h0000_5555;
        step();
        chk("abort.busy", {31'b0, busy}, 32'd1);
        start = 1'b0; rst_n = 1'b0;
        step();
        chk("abort.fin", {31'b0, finish}, 32'd0);
        chk("abort.res", result, 32'd0);
        chk("abort.zero", {31'b0, zero}, 32'd1);
        chk("abort.busy2", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("abort.fin2", {31'b0, finish}, 32'd0);
        chk("abort.res2", result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
